// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-level SPI mode-0 master.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StDone
  } spi_state_e;

  localparam int unsigned SPI_DIV_WIDTH   = 8;
  localparam logic        SPI_IDLE_MOSI   = 1'b1;
  localparam logic        SPI_CS_DESELECT = 1'b1;

endpackage

// File: rtl/spi_byte_master_if.sv
// Request/response channels between the SPI controller logic and spi_byte_master.
interface spi_byte_master_if
  import spi_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = SPI_DIV_WIDTH
);

  logic                 req_valid;
  logic                 req_ready;
  logic [7:0]           req_data;
  logic                 req_cs;
  logic [DIV_WIDTH-1:0] div;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [7:0]           resp_data;

  modport master (
    output req_valid, req_data, req_cs, div, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_data, req_cs, div, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/spi_byte_master.sv
// SPI mode-0 byte master: shifts one byte out MSB first per request, returns the byte read
// from MISO. SCLK half-period is div+1 clocks, latched per byte.
module spi_byte_master
  import spi_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = SPI_DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  spi_byte_master_if.slave bus,
  output logic             spi_clk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_cs
);

  spi_state_e           state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] half_q, half_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 clk_q, clk_d;
  logic                 mosi_q, mosi_d;
  logic                 cs_q, cs_d;
  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      div_q        <= '0;
      half_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      clk_q        <= 1'b0;
      mosi_q       <= SPI_IDLE_MOSI;
      cs_q         <= SPI_CS_DESELECT;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      half_q       <= half_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      clk_q        <= clk_d;
      mosi_q       <= mosi_d;
      cs_q         <= cs_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    half_d       = half_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    clk_d        = clk_q;
    mosi_d       = mosi_q;
    cs_d         = cs_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          shift_d     = bus.req_data;
          div_d       = bus.div;
          half_d      = bus.div;
          cs_d        = bus.req_cs;
          bit_d       = 3'd7;
          mosi_d      = bus.req_data[7];
          clk_d       = 1'b0;
          req_ready_d = 1'b0;
          state_d     = StLow;
        end
      end
      StLow: begin
        if (half_q == '0) begin
          half_d  = div_q;
          clk_d   = 1'b1;
          state_d = StHigh;
        end else begin
          half_d = half_q - 1'b1;
        end
      end
      StHigh: begin
        if (half_q == '0) begin
          // Sample at the end of the high phase: MISO was launched on the previous falling edge.
          shift_d = {shift_q[6:0], spi_miso};
          half_d  = div_q;
          clk_d   = 1'b0;
          if (bit_q == 3'd0) begin
            mosi_d       = SPI_IDLE_MOSI;
            resp_valid_d = 1'b1;
            state_d      = StDone;
          end else begin
            bit_d   = bit_q - 3'd1;
            mosi_d  = shift_q[6];
            state_d = StLow;
          end
        end else begin
          half_d = half_q - 1'b1;
        end
      end
      StDone: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = shift_q;
  assign spi_clk        = clk_q;
  assign spi_mosi       = mosi_q;
  assign spi_cs         = cs_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: reset, loopback, slave model, backpressure, divider
// latching, maximum divider and mid-byte reset.
module tb_spi_byte_master;
  import spi_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic spi_clk, spi_mosi, spi_miso, spi_cs;

  bit         loopback;
  logic       slave_bit;
  logic [7:0] slave_tx;
  int         slave_idx;

  int n_total = 0;
  int n_bad   = 0;

  spi_byte_master_if #(.DIV_WIDTH(8)) bus ();

  spi_byte_master #(.DIV_WIDTH(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs   (spi_cs)
  );

  assign spi_miso = loopback ? spi_mosi : slave_bit;

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits for req_ready, presents one request and returns one cycle after the accepting edge.
  task automatic send(input logic [7:0] data, input logic cs, input logic [7:0] dv);
    int n = 0;
    while (!bus.req_ready && n < 200) begin
      tick();
      n++;
    end
    check("ready_wait", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_data  = data;
    bus.req_cs    = cs;
    bus.div       = dv;
    if (!loopback) begin
      slave_idx = 7;
      slave_bit = slave_tx[7];
    end
    tick();
    bus.req_valid = 1'b0;
    check("cs_t1", spi_cs, cs);
    check("mosi_t1", spi_mosi, data[7]);
  endtask

  // Follows one byte from T0+1 until resp_valid and checks pin timing and data.
  task automatic run_byte(input string tag, input logic [7:0] data, input logic cs, input int dv,
                          input logic [7:0] exp_rx, input int chg_at, input logic [7:0] chg_div);
    int         c          = 1;
    int         rises      = 0;
    int         first_rise = 0;
    int         hi_len     = 0;
    int         hi_bad     = 0;
    int         cs_bad     = 0;
    int         limit      = 16 * (dv + 1) + 40;
    logic       prev       = 1'b0;
    logic [7:0] tx         = '0;
    while (!bus.resp_valid && c < limit) begin
      if (spi_cs !== cs) cs_bad++;
      if (spi_clk && !prev) begin
        rises++;
        if (first_rise == 0) first_rise = c;
        tx     = {tx[6:0], spi_mosi};
        hi_len = 0;
      end
      if (spi_clk) hi_len++;
      if (!spi_clk && prev) begin
        if (hi_len != dv + 1) hi_bad++;
        if (!loopback && slave_idx > 0) begin
          slave_idx--;
          slave_bit = slave_tx[slave_idx];
        end
      end
      if (c == chg_at) bus.div = chg_div;
      prev = spi_clk;
      tick();
      c++;
    end
    if (prev && hi_len != dv + 1) hi_bad++;
    check($sformatf("%s_resp_cycle", tag), c, 16 * (dv + 1) + 1);
    check($sformatf("%s_rises", tag), rises, 8);
    check($sformatf("%s_first_rise", tag), first_rise, dv + 2);
    check($sformatf("%s_mosi", tag), tx, data);
    check($sformatf("%s_high_len", tag), hi_bad, 0);
    check($sformatf("%s_cs", tag), cs_bad, 0);
    check($sformatf("%s_rx", tag), bus.resp_data, exp_rx);
    check($sformatf("%s_done_clk", tag), spi_clk, 0);
    check($sformatf("%s_done_mosi", tag), spi_mosi, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n_resp;
    reset          = 1'b1;
    loopback       = 1'b1;
    slave_bit      = 1'b1;
    slave_tx       = '0;
    slave_idx      = 0;
    bus.req_valid  = 1'b0;
    bus.req_data   = '0;
    bus.req_cs     = 1'b1;
    bus.div        = '0;
    bus.resp_ready = 1'b1;
    repeat (3) tick();
    check("rst_clk", spi_clk, 0);
    check("rst_mosi", spi_mosi, 1);
    check("rst_cs", spi_cs, 1);
    check("rst_ready", bus.req_ready, 1);
    check("rst_valid", bus.resp_valid, 0);
    check("rst_data", bus.resp_data, 0);
    reset = 1'b0;
    tick();

    // Loopback at maximum SCLK rate.
    send(8'hA5, 1'b0, 8'd0);
    run_byte("lb0", 8'hA5, 1'b0, 0, 8'hA5, 0, 8'd0);
    tick();
    check("lb0_ready", bus.req_ready, 1);
    check("lb0_valid_clr", bus.resp_valid, 0);

    // Mode-0 slave returning 0x96.
    loopback = 1'b0;
    slave_tx = 8'h96;
    send(8'h3C, 1'b0, 8'd3);
    run_byte("sl3", 8'h3C, 1'b0, 3, 8'h96, 0, 8'd0);
    tick();

    // Response backpressure with a second request pending.
    loopback       = 1'b1;
    bus.resp_ready = 1'b0;
    send(8'hC3, 1'b0, 8'd1);
    run_byte("bp", 8'hC3, 1'b0, 1, 8'hC3, 0, 8'd0);
    bus.req_valid = 1'b1;
    bus.req_data  = 8'h5A;
    bus.req_cs    = 1'b1;
    bus.div       = 8'd0;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", bus.resp_valid, 1);
      check("bp_data", bus.resp_data, 8'hC3);
      check("bp_ready", bus.req_ready, 0);
      check("bp_clk", spi_clk, 0);
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    check("bp_ready_after", bus.req_ready, 1);
    check("bp_valid_after", bus.resp_valid, 0);
    tick();
    bus.req_valid = 1'b0;
    check("bp2_accepted", bus.req_ready, 0);
    check("bp2_cs", spi_cs, 1);
    check("bp2_mosi", spi_mosi, 0);
    run_byte("bp2", 8'h5A, 1'b1, 0, 8'h5A, 0, 8'd0);
    tick();

    // Init dummy byte: div changes mid-byte and must not affect it.
    send(8'hFF, 1'b1, 8'd103);
    run_byte("init", 8'hFF, 1'b1, 103, 8'hFF, 50, 8'd0);
    tick();
    send(8'h81, 1'b0, bus.div);
    run_byte("post", 8'h81, 1'b0, 0, 8'h81, 0, 8'd0);
    tick();

    // Largest divider.
    send(8'h5A, 1'b0, 8'd255);
    run_byte("max", 8'h5A, 1'b0, 255, 8'h5A, 0, 8'd0);
    tick();

    // Asynchronous reset during the bit-3 high phase.
    send(8'hE7, 1'b0, 8'd3);
    repeat (37) tick();
    check("mid_pre_clk", spi_clk, 1);
    check("mid_pre_cs", spi_cs, 0);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_clk", spi_clk, 0);
    check("mid_rst_cs", spi_cs, 1);
    check("mid_rst_mosi", spi_mosi, 1);
    check("mid_rst_ready", bus.req_ready, 1);
    check("mid_rst_valid", bus.resp_valid, 0);
    #1 reset = 1'b0;
    n_resp = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.resp_valid) n_resp++;
    end
    check("mid_no_resp", n_resp, 0);
    send(8'h69, 1'b0, 8'd2);
    run_byte("after_rst", 8'h69, 1'b0, 2, 8'h69, 0, 8'd0);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_byte_master.md
# spi_byte_master

Byte-level SPI mode-0 master that drives the SD-card pins (`sd_clk`, `sd_mosi`, `sd_miso`, `sd_cs`) on behalf of the SPI test/controller logic. It accepts one byte plus a chip-select level over a valid/ready request channel and shifts it out MSB first. It returns the byte simultaneously shifted in on a valid/ready response channel. The SCLK rate is set per byte, so the same block serves the 400 kHz SD init phase and the fast data phase.

## Interface
- `DIV_WIDTH`, 8, width of the half-period divider input.
- `clock` in 1, system clock (83 MHz domain).
- `reset` in 1, asynchronous, active-high.
- `req_valid` in 1, request byte present.
- `req_ready` out 1, block idle and able to accept.
- `req_data` in 8, byte to transmit.
- `req_cs` in 1, `spi_cs` pin level for this byte: 0 = card selected, 1 = deselected, e.g. for init dummy clocks.
- `div` in DIV_WIDTH, SCLK half-period is `div+1` clock cycles.
- `resp_valid` out 1, received byte present.
- `resp_ready` in 1, consumer accepts response.
- `resp_data` out 8, byte sampled from MISO.
- `spi_clk` out 1, SCLK. CPOL=0.
- `spi_mosi` out 1, MOSI.
- `spi_miso` in 1, MISO.
- `spi_cs` out 1, chip select, active-low pin.

## Operation
- States: IDLE, LOW, HIGH, DONE.
- IDLE: `req_ready`=1.
  - On `req_valid`: latch `req_data` into the shift register, `div` into `div_q`, and `req_cs` into the `spi_cs` register.
  - Load bit counter = 7 and half-period counter = `div_q`. Go to LOW.
- LOW:
  - `spi_clk`=0. `spi_mosi`=shift[7].
  - Half counter decrements each cycle. At 0, go to HIGH and reload the counter.
- HIGH:
  - `spi_clk`=1.
  - On the last cycle of HIGH (counter = 0): sample `spi_miso` into shift[0] after shifting left by 1.
  - If bit counter = 0, go to DONE. Otherwise decrement the bit counter, reload, and go to LOW.
- DONE:
  - `resp_valid`=1, `resp_data`=shift register. `spi_clk`=0.
  - On `resp_ready`, go to IDLE.
- `spi_mosi`=1 in IDLE and DONE.
- `spi_cs` holds its last latched level in all states. It changes only at request acceptance.
- `div` is sampled only at acceptance. Changes mid-byte have no effect.
- Only one transaction is in flight. `req_ready`=0 in LOW, HIGH and DONE, and requests presented then are not consumed.
- `req_ready` is a pure function of state. It has no combinational path from `resp_ready`.
- MISO is not synchronised; SD MISO is launched from our own SCLK. The sample point is the end of the high half-period, which gives maximum setup.
- Reset values, applied immediately on `reset` assertion including mid-transfer:
  - state IDLE, `spi_clk`=0, `spi_mosi`=1, `spi_cs`=1.
  - `req_ready`=1 once in IDLE, `resp_valid`=0, `resp_data`=0.
  - The interrupted byte is discarded with no response.

## Timing
- Accept at cycle T0 (`req_valid && req_ready`).
- From T0+1: `spi_cs` carries the new level and MOSI carries bit 7.
- Bit n (n = 7..0, k = 7-n):
  - low phase: cycles T0+1+2k(div+1) .. T0+(2k+1)(div+1).
  - high phase: the following div+1 cycles.
- `resp_valid` first asserts at T0+16(div+1)+1.
- Back-to-back throughput: response handshake at T1, next request accepted no earlier than T1+1.
- `div`=0 gives SCLK = clock/2, the maximum rate. `div`=2^DIV_WIDTH-1 gives a 256-cycle half-period.
- All outputs are registered.

## Structure
- Package `spi_pkg`:
  - state enum (IDLE, LOW, HIGH, DONE).
  - `DIV_WIDTH` default constant.
  - `SPI_IDLE_MOSI`=1.
  - `SPI_CS_DESELECT`=1.
- Single module; no sub-module. The half-period counter, bit counter and shift register are small enough to stay inline.

## Test plan
- Reset: hold `reset` 3 cycles.
  - Expect `spi_clk`=0, `spi_mosi`=1, `spi_cs`=1, `req_ready`=1, `resp_valid`=0.
  - Pulse `reset` asynchronously between clock edges and check the outputs change before the next edge.
- Loopback, `div`=0: MISO tied to MOSI, send 0xA5 with `req_cs`=0.
  - Expect 8 SCLK pulses, each 1 cycle high, and `spi_cs`=0 from T0+1.
  - Expect `resp_valid` at T0+17 with `resp_data`=0xA5.
- Slave model, `div`=3: send 0x3C while the model returns 0x96 (mode 0).
  - Expect MOSI bits 0,0,1,1,1,1,0,0, each high phase 4 cycles long.
  - Expect `resp_data`=0x96 at T0+65.
- Backpressure: hold `resp_ready`=0 for 10 cycles after `resp_valid` with a second request pending.
  - Expect `resp_valid`/`resp_data` stable, `req_ready`=0 and `spi_clk`=0 throughout.
  - Expect the second request accepted the cycle after the response handshake.
- Divider change and init dummies: send 0xFF with `req_cs`=1, `div`=103, and change `div` to 0 at T0+50.
  - Expect the whole byte timed at 104-cycle half-periods and `spi_cs`=1 throughout.
  - Expect the next byte timed at `div`=0.
- Reset mid-byte: assert `reset` during bit 3 high phase.
  - Expect immediate `spi_clk`=0, `spi_cs`=1 and no response.
  - Expect the next request after release to complete with correct data.
